// File: rtl/prio_enc_pkg.sv
// Shared types and search helpers for the sequential priority encoder.
// Helpers work on a MAX_W-wide vector so any WIDTH up to MAX_W can reuse them.
package prio_enc_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } find_t;

  // First set bit at or after start, wrapping from width-1 back to 0.
  function automatic find_t find_first(input logic [MAX_W-1:0] vec,
                                       input int start,
                                       input int width);
    find_t r;
    int    pos;
    r = '0;
    for (int k = 0; k < MAX_W; k++) begin
      pos = start + k;
      if (pos >= width) pos = pos - width;
      if (k < width && !r.found && vec[pos]) begin
        r.found = 1'b1;
        r.idx   = 32'(pos);
      end
    end
    return r;
  endfunction

  function automatic logic is_single(input logic [MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational find-first-set over a WIDTH-bit vector, starting at a
// given index and wrapping. found=0 and idx=0 for an all-zero vector.
module prio_find
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  find_t res;

  // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    res   = find_first(MAX_W'(vec), int'(start), WIDTH);
    found = res.found && (res.idx < 32'(WIDTH));
    idx   = IDX_W'(res.idx);
  end

endmodule

// File: rtl/prio_encoder_seq.sv
// Sequential bit-vector encoder: one index beat per set bit, valid/ready on both sides.
// Define PRIO_ENC_RR_EN for a persistent round-robin search start (rr_ptr).
module prio_encoder_seq
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [IDX_W-1:0] start;
  logic             found;
  logic             beat;
  logic             accept;

`ifdef PRIO_ENC_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  prio_find #(.WIDTH(WIDTH)) u_find (
    .vec   (pend),
    .start (start),
    .found (found),
    .idx   (out_idx)
  );

  // All beat fields decode from state/pend only; in_data never reaches out_* in the same cycle.
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_none  = out_valid && !found;
  assign out_last  = out_valid && (!found || is_single(MAX_W'(pend)));

  assign beat      = out_valid && out_ready;
  assign in_ready  = enable && ((state == IDLE) || (beat && out_last));
  assign accept    = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
    end else if (accept) begin
      pend  <= in_data;
      state <= EMIT;
    end else if (beat) begin
      pend <= pend & ~(WIDTH'(1) << out_idx);
      if (out_last) state <= IDLE;
    end
  end

`ifdef PRIO_ENC_RR_EN
  // Zero-vector beats leave the pointer where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (beat && found) begin
      rr_ptr <= (out_idx == IDX_W'(WIDTH - 1)) ? '0 : out_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Self-checking bench for prio_encoder_seq (WIDTH=8): directed scenarios plus
// randomized traffic against a beat-list reference model.
module tb_prio_encoder_seq;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_none;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int idx;
    bit last;
    bit none;
  } beat_t;

  beat_t exp_q[$];
  int    cnt_q[$];
  int    m_ptr;

  logic [7:0] obs;
  assign obs = {in_ready, out_valid, out_idx, out_last, out_none, busy};

  prio_encoder_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected beats for one vector: set bits in circular order from the search start.
  task automatic model_push(input logic [7:0] v);
    int cnt, n, p, last_p;
    cnt = $countones(v);
    if (cnt == 0) begin
      exp_q.push_back('{idx: 0, last: 1'b1, none: 1'b1});
      cnt_q.push_back(1);
      return;
    end
    n = 0;
    last_p = 0;
    for (int k = 0; k < 8; k++) begin
      p = (m_ptr + k) % 8;
      if (v[p]) begin
        n++;
        exp_q.push_back('{idx: p, last: (n == cnt), none: 1'b0});
        last_p = p;
      end
    end
`ifdef PRIO_ENC_RR_EN
    m_ptr = (last_p + 1) % 8;
`endif
    cnt_q.push_back(cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) $display("FAIL reset_state got=%b exp=%b", obs, {1'b1, 1'b0, 3'd0, 3'b000});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ascending();
    logic [7:0] e [5];
    e = '{{1'b1, 1'b0, 3'd0, 3'b000}, {1'b0, 1'b1, 3'd2, 3'b001}, {1'b0, 1'b1, 3'd5, 3'b001},
          {1'b1, 1'b1, 3'd7, 3'b101}, {1'b1, 1'b0, 3'd0, 3'b000}};
    in_data = 8'hA4; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (obs !== e[c]) $display("FAIL a4_cycle%0d got=%b exp=%b", c, obs, e[c]);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_zero_vector();
    in_data = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 3'b111}) $display("FAIL zero_beat got=%b exp=%b", obs, {1'b1, 1'b1, 3'd0, 3'b111});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 3'b000}) $display("FAIL zero_idle got=%b exp=%b", obs, {1'b1, 1'b0, 3'd0, 3'b000});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    in_data = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) out_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== {1'b0, 1'b1, 3'd0, 3'b001}) $display("FAIL bp_hold%0d got=%b exp=%b", c, obs, {1'b0, 1'b1, 3'd0, 3'b001});
      else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd7, 3'b101}) $display("FAIL bp_last got=%b exp=%b", obs, {1'b1, 1'b1, 3'd7, 3'b101});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    logic [7:0] e [4];
    e = '{{1'b0, 1'b1, 3'd1, 3'b001}, {1'b0, 1'b1, 3'd2, 3'b101},
          {1'b0, 1'b0, 3'd0, 3'b000}, {1'b0, 1'b0, 3'd0, 3'b000}};
    in_data = 8'h06; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    enable = 1'b0; in_data = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (obs !== e[c]) $display("FAIL en_drop_cycle%0d got=%b exp=%b", c, obs, e[c]);
      else n_pass++;
      @(negedge clk);
    end
    enable = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 3'b000}) $display("FAIL en_restore got=%b exp=%b", obs, {1'b1, 1'b0, 3'd0, 3'b000});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    int base;
`ifdef PRIO_ENC_RR_EN
    base = 3;
`else
    base = 0;
`endif
    in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (obs !== {1'b0, 1'b1, 3'(base + c), 3'b001}) $display("FAIL ff_beat%0d got=%b exp=%b", c, obs, {1'b0, 1'b1, 3'(base + c), 3'b001});
      else n_pass++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 3'b000}) $display("FAIL rst_mid_drain got=%b exp=%b", obs, {1'b1, 1'b0, 3'd0, 3'b000});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    in_data = 8'h10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 3'd4, 3'b101}) $display("FAIL after_rst_beat got=%b exp=%b", obs, {1'b1, 1'b1, 3'd4, 3'b101});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 3'b000}) $display("FAIL after_rst_idle got=%b exp=%b", obs, {1'b1, 1'b0, 3'd0, 3'b000});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [3];
`ifdef PRIO_ENC_RR_EN
    e = '{{1'b1, 1'b1, 3'd3, 3'b101}, {1'b0, 1'b1, 3'd4, 3'b001}, {1'b1, 1'b1, 3'd0, 3'b101}};
`else
    e = '{{1'b1, 1'b1, 3'd3, 3'b101}, {1'b0, 1'b1, 3'd0, 3'b001}, {1'b1, 1'b1, 3'd4, 3'b101}};
`endif
    in_data = 8'h08; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_data = 8'h11;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (obs !== e[c]) $display("FAIL b2b_cycle%0d got=%b exp=%b", c, obs, e[c]);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    beat_t b;
    bit    exp_valid, exp_ready;
    int    obs_cnt;
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; obs_cnt = 0;
    exp_q.delete(); cnt_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 570) begin
        in_valid  = ($urandom_range(0, 2) != 0);
        in_data   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 9) != 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; enable = 1'b1;
      end
      #1;
      exp_valid = (exp_q.size() != 0);
      exp_ready = enable && (!exp_valid || (out_ready && exp_q[0].last));
      n_checks++;
      if ({in_ready, out_valid, busy} !== {exp_ready, exp_valid, exp_valid})
        $display("FAIL rnd_hs cyc%0d got=%b exp=%b", cyc, {in_ready, out_valid, busy}, {exp_ready, exp_valid, exp_valid});
      else n_pass++;
      if (exp_valid) begin
        b = exp_q[0];
        n_checks++;
        if ({out_idx, out_last, out_none} !== {3'(b.idx), b.last, b.none})
          $display("FAIL rnd_beat cyc%0d got=%b exp=%b", cyc, {out_idx, out_last, out_none}, {3'(b.idx), b.last, b.none});
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        obs_cnt++;
        if (out_last) begin
          n_checks++;
          if (cnt_q.size() == 0) $display("FAIL rnd_count cyc%0d got=%0d exp=none", cyc, obs_cnt);
          else if (obs_cnt !== cnt_q[0]) $display("FAIL rnd_count cyc%0d got=%0d exp=%0d", cyc, obs_cnt, cnt_q[0]);
          else n_pass++;
          if (cnt_q.size() != 0) void'(cnt_q.pop_front());
          obs_cnt = 0;
        end
      end
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) model_push(in_data);
      @(negedge clk);
    end
    #1;
    n_checks++;
    if ({out_valid, exp_q.size() == 0} !== 2'b01) $display("FAIL rnd_drain got=%b exp=01", {out_valid, exp_q.size() == 0});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_zero_vector();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_drain();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
